ball_motion: RTL and testbench
==============================

BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  X_CENTER  320  reset X position
  Y_CENTER  240  reset Y position
  X_MIN  0  left wall
  X_MAX  639  right wall
  Y_MIN  0  top wall
  Y_MAX  479  bottom wall
  STEP  1  pixels moved per frame
  SIZE  4  ball radius
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  input  1  single system/VGA clock
  reset  input  1  synchronous, active-high reset
  vsync  input  1  vertical sync from the VGA timing stage, clk domain
  keycode  input  8  USB HID keycode, 0x00 = no key
  BallX  output  10  ball centre X, consumed by the colour mapping stage
  BallY  output  10  ball centre Y
  Ball_size  output  10  ball radius, constant SIZE
  frame_tick  output  1  one-cycle pulse on each position update
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, no asynchronous logic.

Function
REQ-004 SHALL register vsync into vsync_q; tick = vsync & ~vsync_q (rising edge).
REQ-005 SHALL update the motion and position registers only on the clk edge where tick=1; registers hold on all other cycles.
REQ-006 SHALL assert frame_tick on the cycle after a tick edge, exactly 1 cycle wide, coincident with the first cycle showing the new BallX/BallY.
REQ-007 SHALL hold X_motion and Y_motion as 10-bit two's complement values in {-STEP, 0, +STEP}.
REQ-008 SHALL decode keys, applied at tick: 0x1A (W) -> X=0, Y=-STEP; 0x16 (S) -> X=0, Y=+STEP; 0x04 (A) -> X=-STEP, Y=0; 0x07 (D) -> X=+STEP, Y=0; any other code keeps the current motion.
REQ-009 SHALL evaluate walls per axis, with priority over keys on that axis: BallX+SIZE >= X_MAX -> X wall hit high; BallX <= X_MIN+SIZE -> X wall hit low; Y is treated identically with Y_MIN/Y_MAX.
REQ-010 SHALL compute new position = old position + new motion, modulo 2^10, in the same tick cycle (no extra latency).
REQ-011 SHALL keep the ball within [MIN+SIZE, MAX-SIZE] on each axis after every tick; if addition would exceed the range, the result is clamped to the bound.
REQ-012 SHALL drive Ball_size = SIZE constantly, including during reset.
REQ-013 SHALL treat vsync held high across many cycles as a single tick; vsync toggling every cycle yields a tick every second cycle.
REQ-014 SHALL ignore keycode changes between ticks; only the value sampled at the tick edge matters.

Reset
REQ-015 SHALL, when reset=1 at a clk edge, set BallX=X_CENTER, BallY=Y_CENTER, X_motion=0, Y_motion=0, vsync_q=0, frame_tick=0.
REQ-016 SHALL let reset win over a simultaneous tick; a tick coinciding with reset deassertion is not lost if vsync rises on that same edge (vsync_q samples from 0).
REQ-017 SHALL abandon any in-progress motion when reset is asserted mid-frame, with no residual update afterwards.

Configuration
REQ-018 SHALL honour macro BALL_BOUNCE_EN: when defined, a wall hit sets that axis motion to the opposite sign (high wall -> -STEP, low wall -> +STEP).
REQ-019 SHALL, without BALL_BOUNCE_EN, on a wall hit set that axis motion to 0 and clamp the position to the bound; a key pointing away from the wall resumes motion.

Verification
REQ-020 Reset: reset=1 for 2 cycles -> BallX=320, BallY=240, Ball_size=4, frame_tick=0.
REQ-021 Key D with 3 vsync rising edges -> BallX=321, 322, 323 and BallY=240; frame_tick pulses 3 times, each 1 cycle wide.
REQ-022 BALL_BOUNCE_EN defined, BallX driven to 635 moving +1 -> next tick gives X_motion=-1 and BallX=634.
REQ-023 BALL_BOUNCE_EN undefined, same setup as REQ-022 -> BallX=635 stays stable; key A then moves it to 634.
REQ-024 vsync held high for 100 cycles -> exactly one position update; keycode changed mid-frame has no effect until the next edge.
REQ-025 reset asserted on the same edge as a vsync rise while moving -> position returns to 320/240 with no update applied.

Source files
------------

// File: rtl/ball_motion.sv
// ---------------------------------------------------------------------------
// ball_motion
//   Moves a ball centre one step per video frame. Frames are marked by the
//   rising edge of vsync. WASD keycodes steer the ball, and the walls win
//   over the keys on their own axis. The centre always stays inside
//   [MIN+SIZE, MAX-SIZE] on both axes.
//
//   Optional feature macro: BALL_BOUNCE_EN
//     defined   : a wall hit reverses that axis (high wall -> -STEP,
//                 low wall -> +STEP)
//     undefined : a wall hit stops that axis at the bound; a key pointing
//                 away from the wall starts it moving again
//
// Ports
//   clk        in   1   system/VGA clock
//   reset      in   1   synchronous, active-high reset
//   vsync      in   1   vertical sync, already in the clk domain
//   keycode    in   8   USB HID keycode, 0x00 = no key
//   BallX      out  10  ball centre X
//   BallY      out  10  ball centre Y
//   Ball_size  out  10  ball radius, constant SIZE
//   frame_tick out  1   one-cycle pulse, aligned with each new position
// ---------------------------------------------------------------------------
module ball_motion #(
   parameter int X_CENTER = 320,
   parameter int Y_CENTER = 240,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 639,
   parameter int Y_MIN    = 0,
   parameter int Y_MAX    = 479,
   parameter int STEP     = 1,
   parameter int SIZE     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic [7:0] keycode,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] Ball_size,
   output logic       frame_tick
);

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;

   localparam logic [9:0] STEP_POS = 10'(STEP);
   localparam logic [9:0] STEP_NEG = 10'(-STEP);

   // The position range is checked in 12-bit signed arithmetic so that a
   // step below zero or past 1023 is seen as out of range, not as a wrap.
   localparam logic signed [11:0] X_LO = 12'(X_MIN + SIZE);
   localparam logic signed [11:0] X_HI = 12'(X_MAX - SIZE);
   localparam logic signed [11:0] Y_LO = 12'(Y_MIN + SIZE);
   localparam logic signed [11:0] Y_HI = 12'(Y_MAX - SIZE);

   logic       vsync_q;
   logic       tick;
   logic [9:0] x_motion, y_motion;
   logic [9:0] x_key, y_key;
   logic       x_hit_hi, x_hit_lo, y_hit_hi, y_hit_lo;
   logic [9:0] x_motion_nxt, y_motion_nxt;
   logic [9:0] x_pos_nxt, y_pos_nxt;

   // Chooses the motion for one axis once the wall state of that axis is known.
   function automatic logic [9:0] wall_motion(input logic       hit_hi,
                                              input logic       hit_lo,
                                              input logic [9:0] key_motion);
      logic [9:0] m;
      m = key_motion;
`ifdef BALL_BOUNCE_EN
      if (hit_hi)      m = STEP_NEG;
      else if (hit_lo) m = STEP_POS;
`else
      // Stop at the wall unless the requested motion already points away.
      if (hit_hi)      m = (key_motion == STEP_NEG) ? STEP_NEG : '0;
      else if (hit_lo) m = (key_motion == STEP_POS) ? STEP_POS : '0;
`endif
      return m;
   endfunction

   // Adds the signed motion to the position and clamps the result to [lo, hi].
   function automatic logic [9:0] step_pos(input logic [9:0]        pos,
                                           input logic [9:0]        mot,
                                           input logic signed [11:0] lo,
                                           input logic signed [11:0] hi);
      logic signed [11:0] sum;
      sum = $signed({2'b00, pos}) + $signed({{2{mot[9]}}, mot});
      if (sum < lo)      sum = lo;
      else if (sum > hi) sum = hi;
      return sum[9:0];
   endfunction

   assign Ball_size = 10'(SIZE);

   always_comb begin
      // NOTE: every variable written here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      tick  = vsync & ~vsync_q;
      x_key = x_motion;
      y_key = y_motion;
      case (keycode)
         KEY_W: begin x_key = '0;       y_key = STEP_NEG; end
         KEY_S: begin x_key = '0;       y_key = STEP_POS; end
         KEY_A: begin x_key = STEP_NEG; y_key = '0;       end
         KEY_D: begin x_key = STEP_POS; y_key = '0;       end
         default: ;
      endcase

      x_hit_hi = ({1'b0, BallX} + 11'(SIZE)) >= 11'(X_MAX);
      x_hit_lo = BallX <= 10'(X_MIN + SIZE);
      y_hit_hi = ({1'b0, BallY} + 11'(SIZE)) >= 11'(Y_MAX);
      y_hit_lo = BallY <= 10'(Y_MIN + SIZE);

      x_motion_nxt = wall_motion(x_hit_hi, x_hit_lo, x_key);
      y_motion_nxt = wall_motion(y_hit_hi, y_hit_lo, y_key);

      // The new motion is applied in the same tick cycle, so there is no
      // extra frame of latency between a key press and the movement.
      x_pos_nxt = step_pos(BallX, x_motion_nxt, X_LO, X_HI);
      y_pos_nxt = step_pos(BallY, y_motion_nxt, Y_LO, Y_HI);
   end

   // NOTE: state is updated with non-blocking assignments so that every
   // register samples the values from before this clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         frame_tick <= 1'b0;
         x_motion   <= '0;
         y_motion   <= '0;
         BallX      <= 10'(X_CENTER);
         BallY      <= 10'(Y_CENTER);
      end else begin
         vsync_q    <= vsync;
         frame_tick <= tick;
         if (tick) begin
            x_motion <= x_motion_nxt;
            y_motion <= y_motion_nxt;
            BallX    <= x_pos_nxt;
            BallY    <= y_pos_nxt;
         end
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// ---------------------------------------------------------------------------
// tb_ball_motion
//   Directed test of ball_motion: reset, keyed motion, vsync edge
//   detection, wall handling (with or without BALL_BOUNCE_EN) and reset in
//   the middle of motion. Inputs are driven and outputs sampled on the
//   falling clock edge.
// ---------------------------------------------------------------------------
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic [7:0] keycode;
   logic [9:0] BallX, BallY, Ball_size;
   logic       frame_tick;

   int total = 0;
   int bad   = 0;
   int exp_x = 320;
   int exp_y = 240;

   ball_motion dut (
      .clk       (clk),
      .reset     (reset),
      .vsync     (vsync),
      .keycode   (keycode),
      .BallX     (BallX),
      .BallY     (BallY),
      .Ball_size (Ball_size),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // One frame: vsync rises with the key applied, then falls. ft1 is
   // frame_tick in the cycle after the edge, ft2 is frame_tick one cycle later.
   task automatic do_tick(input logic [7:0] key, output logic ft1, output logic ft2);
      @(negedge clk);
      keycode = key;
      vsync   = 1'b1;
      @(negedge clk);
      ft1   = frame_tick;
      vsync = 1'b0;
      @(negedge clk);
      ft2 = frame_tick;
   endtask

   task automatic test_reset;
      reset = 1'b1; vsync = 1'b0; keycode = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (BallX !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d want=320", BallX); end
      total++; if (BallY !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d want=240", BallY); end
      total++; if (Ball_size !== 10'd4) begin bad++; $display("FAIL reset_size got=%0d want=4", Ball_size); end
      total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_key_d;
      logic ft1, ft2;
      for (int i = 1; i <= 3; i++) begin
         do_tick(8'h07, ft1, ft2);
         exp_x++;
         total++; if (ft1 !== 1'b1) begin bad++; $display("FAIL key_d_pulse%0d got=%b want=1", i, ft1); end
         total++; if (ft2 !== 1'b0) begin bad++; $display("FAIL key_d_width%0d got=%b want=0", i, ft2); end
         total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL key_d_x%0d got=%0d want=%0d", i, BallX, exp_x); end
         total++; if (BallY !== 10'd240) begin bad++; $display("FAIL key_d_y%0d got=%0d want=240", i, BallY); end
      end
   endtask

   // vsync toggling every cycle: 10 toggles give 5 rising edges.
   task automatic test_back_to_back;
      int pulses = 0;
      @(negedge clk);
      keycode = 8'h07;
      for (int i = 0; i < 10; i++) begin
         vsync = ~vsync;
         @(negedge clk);
         pulses += int'(frame_tick);
      end
      vsync = 1'b0;
      repeat (2) begin @(negedge clk); pulses += int'(frame_tick); end
      exp_x += 5;
      total++; if (pulses != 5) begin bad++; $display("FAIL toggle_pulses got=%0d want=5", pulses); end
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL toggle_x got=%0d want=%0d", BallX, exp_x); end
   endtask

   task automatic test_right_wall;
      logic ft1, ft2;
      while (exp_x < 635) begin do_tick(8'h07, ft1, ft2); exp_x++; end
      total++; if (BallX !== 10'd635) begin bad++; $display("FAIL wall_reach_x got=%0d want=635", BallX); end
      do_tick(8'h07, ft1, ft2);
`ifdef BALL_BOUNCE_EN
      exp_x = 634;
`else
      exp_x = 635;
`endif
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL wall_hit_x got=%0d want=%0d", BallX, exp_x); end
      do_tick(8'h04, ft1, ft2);
      exp_x--;
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL wall_leave_x got=%0d want=%0d", BallX, exp_x); end
      total++; if (ft1 !== 1'b1) begin bad++; $display("FAIL wall_leave_pulse got=%b want=1", ft1); end
   endtask

   // vsync held high for 100 cycles with a key change in the middle.
   task automatic test_vsync_held;
      logic ft1, ft2;
      int pulses = 0;
      @(negedge clk);
      keycode = 8'h04;
      vsync   = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         pulses += int'(frame_tick);
         if (i == 50) keycode = 8'h07;
      end
      vsync = 1'b0;
      @(negedge clk);
      exp_x--;
      total++; if (pulses != 1) begin bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL held_x got=%0d want=%0d", BallX, exp_x); end
      // The mid-frame D was never sampled, so the ball keeps moving left.
      do_tick(8'h00, ft1, ft2);
      exp_x--;
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL held_next_x got=%0d want=%0d", BallX, exp_x); end
   endtask

   task automatic test_top_wall;
      logic ft1, ft2;
      while (exp_y > 4) begin do_tick(8'h1A, ft1, ft2); exp_y--; end
      total++; if (BallY !== 10'd4) begin bad++; $display("FAIL top_reach_y got=%0d want=4", BallY); end
      total++; if (BallX !== 10'(exp_x)) begin bad++; $display("FAIL top_x_still got=%0d want=%0d", BallX, exp_x); end
      do_tick(8'h1A, ft1, ft2);
`ifdef BALL_BOUNCE_EN
      exp_y = 5;
`else
      exp_y = 4;
`endif
      total++; if (BallY !== 10'(exp_y)) begin bad++; $display("FAIL top_hit_y got=%0d want=%0d", BallY, exp_y); end
      do_tick(8'h16, ft1, ft2);
      exp_y++;
      total++; if (BallY !== 10'(exp_y)) begin bad++; $display("FAIL top_leave_y got=%0d want=%0d", BallY, exp_y); end
   endtask

   task automatic test_reset_mid;
      // The ball is moving down; reset and a vsync rise share the same edge.
      @(negedge clk);
      reset   = 1'b1;
      vsync   = 1'b1;
      keycode = 8'h16;
      @(negedge clk);
      total++; if (BallX !== 10'd320) begin bad++; $display("FAIL rst_mid_x got=%0d want=320", BallX); end
      total++; if (BallY !== 10'd240) begin bad++; $display("FAIL rst_mid_y got=%0d want=240", BallY); end
      total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_tick got=%b want=0", frame_tick); end
      // Release reset with vsync still high: the first edge is a tick, and
      // with no key the cleared motion must leave the ball at the centre.
      reset   = 1'b0;
      keycode = 8'h00;
      @(negedge clk);
      total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL rst_rel_tick got=%b want=1", frame_tick); end
      total++; if (BallY !== 10'd240) begin bad++; $display("FAIL rst_rel_y got=%0d want=240", BallY); end
      vsync = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (BallX !== 10'd320 || BallY !== 10'd240) begin
         bad++; $display("FAIL rst_idle_pos got=%0d/%0d want=320/240", BallX, BallY);
      end
   endtask

   initial begin
      test_reset();
      test_key_d();
      test_back_to_back();
      test_right_wall();
      test_vsync_held();
      test_top_wall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
